adder16: RTL and testbench
==========================

// Module: adder16
// PURPOSE
// - 16-bit carry-lookahead adder/subtractor for the ALU datapath, built from four 4-bit CLA blocks and a lookahead unit.
// - Modes: full 16-bit add, full 16-bit subtract, and paired nibble add/subtract (4 independent 4-bit lanes).
// - Result and carry are combinational (zero latency). Registered copies plus an overflow flag are provided for pipelined consumers.
// PARAMETERS
// - none (width fixed at 16, lane width fixed at 4)
// PORTS
// - clk     in   1   clock; rising edge; clocks the registered outputs only
// - rst     in   1   synchronous reset, active-high
// - a       in   16  operand A (two's complement)
// - b       in   16  operand B (two's complement)
// - padd    in   1   1 = four independent nibble lanes; 0 = full 16-bit operation
// - sub     in   1   1 = subtract (a - b); 0 = add (a + b)
// - sum     out  16  combinational result
// - cout    out  1   combinational carry out of bit 15 (top lane when padd=1)
// - sum_q   out  16  sum registered on clk
// - cout_q  out  1   cout registered on clk
// - ovf_q   out  1   registered signed-overflow flag
// BEHAVIOUR
// - Subtract: b_eff = ~b, carry-in = 1. Add: b_eff = b, carry-in = 0. Implemented as a single adder datapath, with no separate subtractor.
// - Each 4-bit block produces per-bit g = a&b_eff and p = a^b_eff, plus group G/P. The lookahead unit computes c4, c8, c12 and c16 from group G/P and the carry-in. No ripple is allowed between blocks.
// - padd=0: sum = a + b_eff + cin, taken mod 2^16. cout = c16.
// - For subtract, cout=1 means no borrow (a >= b unsigned).
// - padd=1: inter-lane carries are forced off, and every lane gets carry-in = sub.
// - For lane i: sum[4i+3:4i] = a_lane + b_eff_lane + sub, mod 16. Each lane wraps, with no saturation.
// - cout = carry out of lane 3 (bits 15:12). Lane carries 0..2 are discarded.
// - Example (padd=1, sub=0): a=0x9F8E, b=0x8181 -> sum=0x100F.
// - Overflow: padd=0 -> ovf = carry into bit 15 XOR c16.
// - Overflow: padd=1 -> ovf = OR over lanes of (carry into lane MSB XOR lane carry out).
// - sum and cout settle within the same cycle. No clock is involved, and rst has no effect on them.
// - Rising clk with rst=1: sum_q=0, cout_q=0, ovf_q=0.
// - Rising clk with rst=0: sum_q<=sum, cout_q<=cout, ovf_q<=ovf. Latency is 1 cycle.
// - Mode or operand changes mid-cycle: the combinational outputs follow immediately. The registered outputs capture values at the edge only.
// - Reset asserted mid-stream clears the registers on that edge. The combinational path is unaffected.
// - X/Z on inputs is not supported.
// TESTING
// - Add (padd=0, sub=0):
//   - a=0x1234, b=0x1111 -> sum=0x2345, cout=0
//   - a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1, ovf=0
// - Signed overflow: a=0x7FFF, b=0x0001, add -> sum=0x8000, cout=0, ovf=1.
// - Subtract (sub=1):
//   - a=0x0007, b=0x0005 -> sum=0x0002, cout=1
//   - a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0
// - Nibble mode (padd=1):
//   - sub=0: a=0x9F8E, b=0x8181 -> sum=0x100F, cout=1
//   - sub=1: a=0x1234, b=0x2222 -> sum=0xF012
// - Registers:
//   - rst=1 for one edge -> sum_q=0, cout_q=0, ovf_q=0
//   - next edge with a=0x0003, b=0x0004, add -> sum_q=0x0007
// - Random: at least 150 random a/b vectors per mode (add, sub, padd add, padd sub), each compared to a behavioural model (a+b, a-b, per-nibble sums). Any mismatch fails.

Source files
------------

// File: rtl/adder16.sv
`default_nettype none
// ============================================================================
// Module   : adder16
// Brief    : 16-bit carry-lookahead adder/subtractor. It is built from four
//            4-bit CLA blocks and a group lookahead unit. It supports full
//            16-bit add/sub and four independent nibble lanes. The result is
//            combinational, and registered copies plus an overflow flag are
//            provided.
// Revision : 1.0 - initial release
// ============================================================================
module adder16 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        padd,
    input  logic        sub,
    output logic [15:0] sum,
    output logic        cout,
    output logic [15:0] sum_q,
    output logic        cout_q,
    output logic        ovf_q
);

    localparam int c_LANES = 4;

    // Subtraction reuses the adder: invert B and inject a carry-in of one.
    logic [15:0]        w_b_eff;
    logic [15:0]        w_sum;
    logic [c_LANES-1:0] w_gg;        // group generate per block
    logic [c_LANES-1:0] w_gp;        // group propagate per block
    logic [c_LANES:0]   w_c_la;      // lookahead carries c0, c4, c8, c12, c16
    logic [c_LANES-1:0] w_blk_cin;   // carry-in actually applied to each block
    logic [c_LANES-1:0] w_blk_c3;    // carry into each block's MSB
    logic [c_LANES-1:0] w_blk_cout;  // each block's own carry out (lane carry)
    logic               w_cout;
    logic               w_ovf;

    assign w_b_eff = b ^ {16{sub}};

    // Four 4-bit CLA blocks. Internal carries are derived from the block
    // carry-in through the lookahead equations, so no bit ripples.
    for (genvar gi = 0; gi < c_LANES; gi++) begin : g_blk
        logic [3:0] w_g;
        logic [3:0] w_p;
        logic [3:0] w_c;

        assign w_g = a[4*gi +: 4] & w_b_eff[4*gi +: 4];
        assign w_p = a[4*gi +: 4] ^ w_b_eff[4*gi +: 4];

        assign w_c[0] = w_blk_cin[gi];
        assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
        assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
        assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                      | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);

        assign w_gg[gi] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                        | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
        assign w_gp[gi] = &w_p;

        assign w_sum[4*gi +: 4] = w_p ^ w_c;
        assign w_blk_c3[gi]     = w_c[3];
        assign w_blk_cout[gi]   = w_gg[gi] | (w_gp[gi] & w_blk_cin[gi]);
    end

    // The group lookahead unit forms the block boundary carries directly from
    // the group G/P values and c0.
    assign w_c_la[0] = sub;
    assign w_c_la[1] = w_gg[0] | (w_gp[0] & w_c_la[0]);
    assign w_c_la[2] = w_gg[1] | (w_gp[1] & w_gg[0])
                     | (w_gp[1] & w_gp[0] & w_c_la[0]);
    assign w_c_la[3] = w_gg[2] | (w_gp[2] & w_gg[1])
                     | (w_gp[2] & w_gp[1] & w_gg[0])
                     | (w_gp[2] & w_gp[1] & w_gp[0] & w_c_la[0]);
    assign w_c_la[4] = w_gg[3] | (w_gp[3] & w_gg[2])
                     | (w_gp[3] & w_gp[2] & w_gg[1])
                     | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                     | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & w_c_la[0]);

    // In nibble mode the boundary carries are cut, and every lane restarts
    // with the sub bit as its carry-in.
    assign w_blk_cin[0] = sub;
    assign w_blk_cin[1] = padd ? sub : w_c_la[1];
    assign w_blk_cin[2] = padd ? sub : w_c_la[2];
    assign w_blk_cin[3] = padd ? sub : w_c_la[3];

    // Signed overflow is the carry into the MSB XOR the carry out. This is
    // tested per lane in nibble mode and over the full word otherwise.
    assign w_cout = padd ? w_blk_cout[3] : w_c_la[4];
    assign w_ovf  = padd ? |(w_blk_c3 ^ w_blk_cout)
                         : (w_blk_c3[3] ^ w_c_la[4]);

    assign sum  = w_sum;
    assign cout = w_cout;

    // Pipeline copies of the result for downstream consumers. Only these
    // copies are reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= 16'h0000;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sum_q  <= w_sum;
            cout_q <= w_cout;
            ovf_q  <= w_ovf;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adder16.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder16
// Brief    : Self-checking bench for adder16. It applies a directed vector
//            table, then register/reset sequences, then random vectors that
//            are compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder16;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        padd;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic [15:0] sum_q;
    logic        cout_q;
    logic        ovf_q;

    int n_pass;
    int n_total;

    typedef struct {
        logic        padd;
        logic        sub;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs[14];

    adder16 u_dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .padd   (padd),
        .sub    (sub),
        .sum    (sum),
        .cout   (cout),
        .sum_q  (sum_q),
        .cout_q (cout_q),
        .ovf_q  (ovf_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    // Behavioural reference: integer arithmetic, range-checked for overflow.
    task automatic model(input logic m_padd, input logic m_sub,
                         input logic [15:0] ma, input logic [15:0] mb,
                         output logic [15:0] s, output logic co, output logic ov);
        int sa, sb, r, la, lb, lr, sla, slb, slr;
        s  = 16'h0000;
        co = 1'b0;
        ov = 1'b0;
        if (!m_padd) begin
            s  = m_sub ? (ma - mb) : (ma + mb);
            co = m_sub ? (ma >= mb) : ((32'(ma) + 32'(mb)) > 32'hFFFF);
            sa = int'($signed(ma));
            sb = int'($signed(mb));
            r  = m_sub ? (sa - sb) : (sa + sb);
            ov = (r > 32767) || (r < -32768);
        end else begin
            for (int i = 0; i < 4; i++) begin
                la  = int'(ma[4*i +: 4]);
                lb  = int'(mb[4*i +: 4]);
                lr  = m_sub ? (la - lb) : (la + lb);
                s[4*i +: 4] = lr[3:0];
                if (i == 3) co = m_sub ? (la >= lb) : (lr > 15);
                sla = (la > 7) ? la - 16 : la;
                slb = (lb > 7) ? lb - 16 : lb;
                slr = m_sub ? (sla - slb) : (sla + slb);
                if ((slr > 7) || (slr < -8)) ov = 1'b1;
            end
        end
    endtask

    // Drive one vector at negedge, check the combinational outputs, then
    // check the registered outputs after the next rising edge.
    task automatic apply(input string tag, input logic v_padd, input logic v_sub,
                         input logic [15:0] va, input logic [15:0] vb,
                         input logic [15:0] es, input logic eco, input logic eov);
        @(negedge clk);
        padd = v_padd;
        sub  = v_sub;
        a    = va;
        b    = vb;
        #1;
        check({tag, " sum"},  sum, es);
        check({tag, " cout"}, 16'(cout), 16'(eco));
        @(posedge clk);
        #1;
        check({tag, " sum_q"},  sum_q, es);
        check({tag, " cout_q"}, 16'(cout_q), 16'(eco));
        check({tag, " ovf_q"},  16'(ovf_q), 16'(eov));
    endtask

    initial begin
        logic [15:0] ms;
        logic        mco;
        logic        mov;
        logic [15:0] ra;
        logic [15:0] rb;

        n_pass  = 0;
        n_total = 0;
        rst  = 1'b1;
        a    = 16'h0000;
        b    = 16'h0000;
        padd = 1'b0;
        sub  = 1'b0;

        //        padd  sub   a         b         sum       cout  ovf
        vecs[0]  = '{1'b0, 1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 16'h9F8E, 16'h8181, 16'h100F, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 16'h1234, 16'h2222, 16'hF012, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 16'h7777, 16'h1111, 16'h8888, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 16'h0FFF, 16'h0001, 16'h1000, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 16'h0FFF, 16'h0001, 16'h0FF0, 1'b0, 1'b0};

        // Reset clears the registers after a single edge.
        @(posedge clk);
        #1;
        check("reset sum_q",  sum_q, 16'h0000);
        check("reset cout_q", 16'(cout_q), 16'h0000);
        check("reset ovf_q",  16'(ovf_q), 16'h0000);

        // The first edge out of reset captures 3 + 4.
        @(negedge clk);
        rst = 1'b0;
        a   = 16'h0003;
        b   = 16'h0004;
        @(posedge clk);
        #1;
        check("first sum_q", sum_q, 16'h0007);

        for (int i = 0; i < 14; i++) begin
            apply($sformatf("vec%0d", i), vecs[i].padd, vecs[i].sub, vecs[i].a,
                  vecs[i].b, vecs[i].s, vecs[i].co, vecs[i].ov);
        end

        // An operand change mid-cycle shows on sum at once; sum_q holds.
        @(negedge clk);
        padd = 1'b0;
        sub  = 1'b0;
        a    = 16'h1234;
        b    = 16'h1111;
        @(posedge clk);
        #2;
        a = 16'h0100;
        b = 16'h0023;
        #1;
        check("midcycle sum",   sum,   16'h0123);
        check("midcycle sum_q", sum_q, 16'h2345);

        // Reset mid-stream clears the registers; the combinational path is unaffected.
        @(negedge clk);
        rst = 1'b1;
        a   = 16'h7FFF;
        b   = 16'h0001;
        #1;
        check("rst comb sum",  sum, 16'h8000);
        check("rst comb cout", 16'(cout), 16'h0000);
        @(posedge clk);
        #1;
        check("rst mid sum_q",  sum_q, 16'h0000);
        check("rst mid ovf_q",  16'(ovf_q), 16'h0000);
        check("rst mid cout_q", 16'(cout_q), 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        // Random vectors in each of the four modes.
        for (int m = 0; m < 4; m++) begin
            for (int k = 0; k < 150; k++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                model(m[1], m[0], ra, rb, ms, mco, mov);
                apply($sformatf("rnd m%0d k%0d a=%04h b=%04h", m, k, ra, rb),
                      m[1], m[0], ra, rb, ms, mco, mov);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
